// File: rtl/instr_register_calc.sv
// Instruction register responder: two-stage write pipeline into a 32-entry array with a registered read port.
// Optional read-after-write bypass when compiled with INSTR_REG_FWD_EN defined.
module instr_register_calc #(
    parameter int NUM_ENTRIES = 32,
    parameter int ADDR_W      = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] write_pointer,
    input  logic [3:0]        opcode,
    input  logic [31:0]       operand_a,
    input  logic [31:0]       operand_b,
    input  logic [ADDR_W-1:0] read_pointer,
    output logic [131:0]      instruction_word,
    output logic              busy,
    output logic              div_zero_err
);

    typedef enum logic [3:0] {
        OP_ZERO  = 4'd0,
        OP_PASSA = 4'd1,
        OP_PASSB = 4'd2,
        OP_ADD   = 4'd3,
        OP_SUB   = 4'd4,
        OP_MULT  = 4'd5,
        OP_DIV   = 4'd6,
        OP_MOD   = 4'd7
    } opcode_e;

    // Operands are widened to 64 bits first so DIV of the most negative value by -1 cannot overflow.
    function automatic logic signed [63:0] calc_result(
        input logic [3:0]         op,
        input logic signed [31:0] a,
        input logic signed [31:0] b
    );
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        r  = '0;
        case (op)
            OP_PASSA: r = sa;
            OP_PASSB: r = sb;
            OP_ADD:   r = sa + sb;
            OP_SUB:   r = sa - sb;
            OP_MULT:  r = sa * sb;
            OP_DIV:   if (sb != 64'sd0) r = sa / sb;
            OP_MOD:   if (sb != 64'sd0) r = sa % sb;
            default:  r = '0;
        endcase
        return r;
    endfunction

    logic [131:0]        mem_q [NUM_ENTRIES];

    logic                vld_p1_q;
    logic [ADDR_W-1:0]   ptr_p1_q;
    logic [3:0]          opc_p1_q;
    logic signed [31:0]  a_p1_q;
    logic signed [31:0]  b_p1_q;

    logic signed [63:0]  result_p2;
    logic [131:0]        commit_p2;

    logic [131:0]        word_q;
    logic [131:0]        word_d;
    logic                dz_q;
    logic                dz_d;

    // ---- stage 1: capture the write request ----
    always_ff @(posedge clk) begin
        if (load_en) begin
            ptr_p1_q <= write_pointer;
            opc_p1_q <= opcode;
            a_p1_q   <= operand_a;
            b_p1_q   <= operand_b;
        end
    end

    // ---- stage 2: compute and commit ----
    always_comb begin
        result_p2 = calc_result(opc_p1_q, a_p1_q, b_p1_q);
        commit_p2 = {opc_p1_q, a_p1_q, b_p1_q, result_p2};
        dz_d      = vld_p1_q && (opc_p1_q == OP_DIV || opc_p1_q == OP_MOD) && (b_p1_q == 32'sd0);
    end

    always_comb begin
        word_d = mem_q[read_pointer];
`ifdef INSTR_REG_FWD_EN
        if (vld_p1_q && (ptr_p1_q == read_pointer)) begin
            word_d = commit_p2;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                mem_q[i] <= '0;
            end
            vld_p1_q <= 1'b0;
            word_q   <= '0;
            dz_q     <= 1'b0;
        end else begin
            if (vld_p1_q) begin
                mem_q[ptr_p1_q] <= commit_p2;
            end
            vld_p1_q <= load_en;
            word_q   <= word_d;
            dz_q     <= dz_d;
        end
    end

    assign instruction_word = word_q;
    assign busy             = vld_p1_q;
    assign div_zero_err     = dz_q;

endmodule

// File: doc/instr_register_calc.md
# instr_register_calc

Design-side responder for the instruction-register testbench interface. It accepts instruction writes (opcode plus two signed operands), computes each result in a two-stage pipeline, stores opcode, operands and result in a 32-entry register array, and returns the addressed entry on a registered read port. It is the DUT that the testbench clocking block drives and samples.

## Interface
- `NUM_ENTRIES`, default 32: array depth. Must equal 2^`ADDR_W`.
- `ADDR_W`, default 5: pointer width.
- `clk` in 1: single clock. All activity occurs on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `load_en` in 1: write request, sampled every edge.
- `write_pointer` in `ADDR_W`: target entry for the write.
- `opcode` in 4: ZERO=0, PASSA=1, PASSB=2, ADD=3, SUB=4, MULT=5, DIV=6, MOD=7. Codes 8–15 are illegal.
- `operand_a` in 32: signed operand A.
- `operand_b` in 32: signed operand B.
- `read_pointer` in `ADDR_W`: entry to read, sampled every edge.
- `instruction_word` out 132: registered read data, packed as {opcode[3:0], op_a[31:0], op_b[31:0], result[63:0]}.
- `busy` out 1: high while a write is in pipeline stage 1.
- `div_zero_err` out 1: one-cycle pulse when a DIV or MOD with op_b = 0 is committed.

## Operation
- Stage 1 (edge N, `load_en`=1):
  - Capture pointer, opcode and operands into stage-1 registers.
  - Set stage-1 valid; `busy`=1 for the following cycle.
- Stage 2 (edge N+1, stage-1 valid):
  - Compute the result from the stage-1 registers.
  - Write {opcode, op_a, op_b, result} into the array at the captured pointer.
  - Clear stage-1 valid unless a new write was sampled on the same edge.
- Back-to-back writes are accepted every cycle with no stall. Two writes to the same pointer commit in order; the last write wins.
- Result arithmetic, 64-bit signed:
  - ZERO: 0.
  - PASSA: sext(a). PASSB: sext(b).
  - ADD: sext(a)+sext(b). SUB: sext(a)−sext(b). Neither can overflow in 64 bits.
  - MULT: full 64-bit signed product.
  - DIV: quotient truncated toward zero. 0x80000000 / −1 = +2147483648, with no overflow.
  - MOD: remainder with the sign of a.
  - DIV or MOD with b=0: result 0 and `div_zero_err` pulses. The entry is still written.
  - Illegal opcode: the opcode is stored as given and the result is 0.
- Read path:
  - At every edge, `instruction_word` <= array[`read_pointer`].
  - Forwarding is controlled by the Configuration section.
- Reset (synchronous, highest priority):
  - All array entries become 0.
  - Stage-1 valid = 0, `busy`=0, `div_zero_err`=0, `instruction_word`=0.
  - A write sampled on the reset edge is discarded. A write sitting in stage 1 at reset is discarded and never commits.

## Timing
- Write latency: sampled at edge N, visible in the array after edge N+1.
- Read latency: `read_pointer` sampled at edge M gives `instruction_word` valid after edge M. The returned data reflects commits made at edges ≤ M−1.
- Read and write to the same pointer at the same edge N: the read returns the old contents.
- Read at edge N+1 of an entry committing at N+1: the result depends on forwarding (see Configuration).
- `busy` and `div_zero_err` are registered outputs with no combinational input-to-output path.
- Pointer arithmetic does not wrap. Each pointer addresses its entry directly, and every value from 0 to 31 is valid.

## Configuration
- `INSTR_REG_FWD_EN` defined:
  - If `read_pointer` at edge M equals the pointer committing at edge M, `instruction_word` takes the stage-2 value directly.
  - A read one edge after the write therefore returns the new entry.
- `INSTR_REG_FWD_EN` undefined:
  - No bypass. The same read returns the pre-write contents.
  - The new entry is visible from edge M+1 onward.

## Test plan
- Reset then read pointers 0–31 -> every `instruction_word` = 0; `busy`=0, `div_zero_err`=0.
- Write ptr 3, ADD, a=7, b=−2, then read ptr 3 two edges later -> {3, 7, −2, 5}.
- Write ptr 0, MULT, a=0x7FFFFFFF, b=0x7FFFFFFF -> result 0x3FFFFFFF00000001. Write ptr 1, DIV, a=0x80000000, b=−1 -> result 0x0000000080000000.
- Write ptr 5, MOD, a=−7, b=2 -> result −1. Write ptr 6, DIV, a=9, b=0 -> result 0 and a single-cycle `div_zero_err` pulse one edge after the write.
- Write ptr 9 (SUB, a=10, b=4), then read ptr 9 on the next edge:
  - With `INSTR_REG_FWD_EN` -> 6.
  - Without it -> previous contents, then 6 one edge later.
- Write ptr 12 on edge N, assert `reset` on edge N+1, then read ptr 12 -> 0. `busy` = 0 after the reset edge.
